// File: rtl/money_accum.sv
// BCD credit accumulator: coin buttons add/subtract one unit per digit weight,
// the vending FSM debits through a price/deduct handshake with ack/nack pulses.
module money_accum #(
    parameter int                   DIGITS       = 4,
    parameter int                   STATE_W      = 3,
    parameter logic [STATE_W-1:0]   ACCEPT_STATE = STATE_W'(1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DIGITS-1:0]       btn,
    input  logic                    switch,
    input  logic [STATE_W-1:0]      state,
    input  logic                    clear,
    input  logic                    deduct_req,
    input  logic [4*DIGITS-1:0]     price,
    output logic [4*DIGITS-1:0]     money_out,
    output logic                    deduct_ack,
    output logic                    deduct_nack,
    output logic                    sat
);

    localparam int               W         = 4 * DIGITS;
    localparam logic [W-1:0]     ALL_NINES = {DIGITS{4'h9}};

    // Returns {carry_out, sum}; digits of a and b are assumed to be valid BCD.
    function automatic logic [W:0] bcd_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic [4:0]   s;
        logic         c;
        r = '0;
        c = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'd0, c};
            if (s > 5'd9) begin
                s = s + 5'd6;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            r[4*i +: 4] = s[3:0];
        end
        return {c, r};
    endfunction

    // Returns {borrow_out, difference}; a borrow out means b > a.
    function automatic logic [W:0] bcd_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic [4:0]   d;
        logic         c;
        r = '0;
        c = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            d = {1'b0, a[4*i +: 4]} - {1'b0, b[4*i +: 4]} - {4'd0, c};
            if (d[4]) begin
                d = d + 5'd10;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            r[4*i +: 4] = d[3:0];
        end
        return {c, r};
    endfunction

    function automatic logic bcd_valid(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    logic [W-1:0]      money_q, money_d;
    logic              ack_q, ack_d;
    logic              nack_q, nack_d;
    logic              sat_q, sat_d;
    logic [DIGITS-1:0] btn_q;

    logic [DIGITS-1:0] rise;
    logic [W-1:0]      coin_op;
    logic [W:0]        add_r;
    logic [W:0]        sub_r;
    logic [W:0]        ded_r;

    always_comb begin
        rise    = btn & ~btn_q;
        coin_op = '0;
        for (int i = 0; i < DIGITS; i++) begin
            coin_op[4*i] = rise[i];
        end
        add_r   = bcd_add(money_q, coin_op);
        sub_r   = bcd_sub(money_q, coin_op);
        ded_r   = bcd_sub(money_q, price);

        money_d = money_q;
        ack_d   = 1'b0;
        nack_d  = 1'b0;
        sat_d   = sat_q;

        // Priority: clear, then debit, then coin buttons.
        if (clear) begin
            money_d = '0;
        end else if (deduct_req) begin
            if (bcd_valid(price) && !ded_r[W]) begin
                money_d = ded_r[W-1:0];
                ack_d   = 1'b1;
            end else begin
                nack_d  = 1'b1;
            end
        end else if ((|rise) && (state == ACCEPT_STATE)) begin
            if (!switch) begin
                if (add_r[W]) begin
                    money_d = ALL_NINES;
                    sat_d   = 1'b1;
                end else begin
                    money_d = add_r[W-1:0];
                end
            end else begin
                if (sub_r[W]) begin
                    money_d = '0;
                    sat_d   = 1'b1;
                end else begin
                    money_d = sub_r[W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            money_q <= '0;
            ack_q   <= 1'b0;
            nack_q  <= 1'b0;
            sat_q   <= 1'b0;
            btn_q   <= '0;
        end else begin
            money_q <= money_d;
            ack_q   <= ack_d;
            nack_q  <= nack_d;
            sat_q   <= sat_d;
            btn_q   <= btn;
        end
    end

    assign money_out   = money_q;
    assign deduct_ack  = ack_q;
    assign deduct_nack = nack_q;
    assign sat         = sat_q;

endmodule

// File: tb/tb_money_accum.sv
// Bench for money_accum: directed scenarios plus random traffic, all checked
// against a decimal-integer model of the credit.
module tb_money_accum;

    logic        clk;
    logic        reset;
    logic [3:0]  btn;
    logic        switch;
    logic [2:0]  state;
    logic        clear;
    logic        deduct_req;
    logic [15:0] price;
    logic [15:0] money_out;
    logic        deduct_ack;
    logic        deduct_nack;
    logic        sat;

    money_accum #(
        .DIGITS       (4),
        .STATE_W      (3),
        .ACCEPT_STATE (3'd1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn         (btn),
        .switch      (switch),
        .state       (state),
        .clear       (clear),
        .deduct_req  (deduct_req),
        .price       (price),
        .money_out   (money_out),
        .deduct_ack  (deduct_ack),
        .deduct_nack (deduct_nack),
        .sat         (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: credit as a plain decimal integer.
    int         m_credit = 0;
    logic       m_sat    = 1'b0;
    logic [3:0] m_prev   = 4'b0;
    logic       m_ack    = 1'b0;
    logic       m_nack   = 1'b0;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int t;
        t = v;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic bcd_ok(input logic [15:0] p);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) if (p[4*i +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

    function automatic int from_bcd(input logic [15:0] p);
        int v;
        int w;
        v = 0;
        w = 1;
        for (int i = 0; i < 4; i++) begin
            v = v + int'(p[4*i +: 4]) * w;
            w = w * 10;
        end
        return v;
    endfunction

    task automatic model_update();
        logic [3:0] rise;
        int op;
        int w;
        rise   = btn & ~m_prev;
        m_ack  = 1'b0;
        m_nack = 1'b0;
        if (reset) begin
            m_credit = 0;
            m_sat    = 1'b0;
            m_prev   = 4'b0;
        end else begin
            if (clear) begin
                m_credit = 0;
            end else if (deduct_req) begin
                if (bcd_ok(price) && m_credit >= from_bcd(price)) begin
                    m_credit = m_credit - from_bcd(price);
                    m_ack    = 1'b1;
                end else begin
                    m_nack   = 1'b1;
                end
            end else if (rise != 4'b0 && state == 3'd1) begin
                op = 0;
                w  = 1;
                for (int i = 0; i < 4; i++) begin
                    if (rise[i]) op = op + w;
                    w = w * 10;
                end
                if (!switch) begin
                    m_credit = m_credit + op;
                    if (m_credit > 9999) begin
                        m_credit = 9999;
                        m_sat    = 1'b1;
                    end
                end else begin
                    m_credit = m_credit - op;
                    if (m_credit < 0) begin
                        m_credit = 0;
                        m_sat    = 1'b1;
                    end
                end
            end
            m_prev = btn;
        end
    endtask

    task automatic check_model(input string tag);
        logic [15:0] em;
        em = to_bcd(m_credit);
        total++;
        assert (money_out === em) else begin
            bad++;
            $error("FAIL %s money_out got=%h exp=%h", tag, money_out, em);
        end
        total++;
        assert (deduct_ack === m_ack) else begin
            bad++;
            $error("FAIL %s deduct_ack got=%b exp=%b", tag, deduct_ack, m_ack);
        end
        total++;
        assert (deduct_nack === m_nack) else begin
            bad++;
            $error("FAIL %s deduct_nack got=%b exp=%b", tag, deduct_nack, m_nack);
        end
        total++;
        assert (sat === m_sat) else begin
            bad++;
            $error("FAIL %s sat got=%b exp=%b", tag, sat, m_sat);
        end
    endtask

    task automatic chk_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs are driven 1 time unit after a rising edge and sampled likewise.
    task automatic step(input string tag);
        model_update();
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic press(input int digit, input int n);
        for (int k = 0; k < n; k++) begin
            btn = 4'b0;
            btn[digit] = 1'b1;
            step("press");
            btn = 4'b0;
            step("release");
        end
    endtask

    task automatic set_credit(input int v);
        logic sw_save;
        int   t;
        sw_save = switch;
        clear = 1'b1;
        step("load_clear");
        clear  = 1'b0;
        state  = 3'd1;
        switch = 1'b0;
        t = v;
        for (int d = 0; d < 4; d++) begin
            press(d, t % 10);
            t = t / 10;
        end
        switch = sw_save;
    endtask

    initial begin
        reset = 1'b1; btn = 4'b0; switch = 1'b0; state = 3'd0;
        clear = 1'b0; deduct_req = 1'b0; price = 16'h0;
        step("reset");
        chk_val("reset_money", money_out, 16'h0000);
        chk_val("reset_flags", {12'b0, deduct_ack, deduct_nack, sat}, 16'h0);
        reset = 1'b0;

        // Basic add with carry, then a held button counts once
        state = 3'd1; switch = 1'b0;
        press(0, 10);
        chk_val("ten_ones", money_out, 16'h0010);
        btn = 4'b0010;
        for (int k = 0; k < 5; k++) step("hold_btn1");
        btn = 4'b0;
        step("hold_release");
        chk_val("held_once", money_out, 16'h0020);

        // Simultaneous rises, then state gating
        set_credit(0);
        btn = 4'b0101; step("dual_rise");
        btn = 4'b0;    step("dual_release");
        chk_val("dual_rise", money_out, 16'h0101);
        state = 3'd2;
        btn = 4'b0101; step("gated_rise");
        btn = 4'b0;    step("gated_release");
        chk_val("gated", money_out, 16'h0101);
        state = 3'd1;

        // Borrow and lower clamp
        set_credit(100);
        switch = 1'b1;
        press(0, 1);
        chk_val("borrow", money_out, 16'h0099);
        set_credit(3);
        press(1, 1);
        chk_val("low_clamp", money_out, 16'h0000);
        chk_val("low_clamp_sat", {15'b0, sat}, 16'h0001);

        // Upper clamp after a fresh reset, then clear keeps sat
        reset = 1'b1; step("reset2"); reset = 1'b0;
        switch = 1'b0;
        set_credit(9995);
        chk_val("load_9995", money_out, 16'h9995);
        press(1, 1);
        chk_val("high_clamp", money_out, 16'h9999);
        chk_val("high_clamp_sat", {15'b0, sat}, 16'h0001);
        clear = 1'b1; step("clear"); clear = 1'b0;
        chk_val("clear_money", money_out, 16'h0000);
        chk_val("clear_keeps_sat", {15'b0, sat}, 16'h0001);

        // Deduct handshake
        set_credit(250);
        price = 16'h0175; deduct_req = 1'b1; step("ded_ok");
        chk_val("ded_ok_money", money_out, 16'h0075);
        chk_val("ded_ok_ack", {15'b0, deduct_ack}, 16'h0001);
        deduct_req = 1'b0; step("ded_ok_after");
        chk_val("ded_ack_one_cycle", {15'b0, deduct_ack}, 16'h0000);
        price = 16'h0100; deduct_req = 1'b1; step("ded_short");
        chk_val("ded_short_nack", {14'b0, deduct_ack, deduct_nack}, 16'h0001);
        chk_val("ded_short_money", money_out, 16'h0075);
        price = 16'h00A0; step("ded_badbcd");
        chk_val("ded_badbcd_nack", {14'b0, deduct_ack, deduct_nack}, 16'h0001);
        deduct_req = 1'b0; step("ded_idle");

        // Priority: deduct beats button, clear beats deduct
        set_credit(50);
        price = 16'h0010; deduct_req = 1'b1; btn = 4'b0001; step("ded_vs_btn");
        chk_val("ded_vs_btn_money", money_out, 16'h0040);
        chk_val("ded_vs_btn_ack", {15'b0, deduct_ack}, 16'h0001);
        deduct_req = 1'b0; btn = 4'b0; step("ded_vs_btn_rel");
        chk_val("rise_lost", money_out, 16'h0040);
        clear = 1'b1; deduct_req = 1'b1; step("clear_vs_ded");
        chk_val("clear_vs_ded", {money_out[13:0], deduct_ack, deduct_nack}, 16'h0000);
        clear = 1'b0; deduct_req = 1'b0;

        // Reset mid-operation discards a pending request
        set_credit(321);
        press(0, 1);
        price = 16'h0001; deduct_req = 1'b1; reset = 1'b1; step("reset_mid");
        chk_val("reset_mid", {money_out[12:0], deduct_ack, deduct_nack, sat}, 16'h0000);
        deduct_req = 1'b0; reset = 1'b0;

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            btn        = 4'($urandom_range(0, 15));
            switch     = ($urandom_range(0, 2) == 0);
            state      = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
            clear      = ($urandom_range(0, 63) == 0);
            deduct_req = ($urandom_range(0, 5) == 0);
            price      = ($urandom_range(0, 3) == 0) ? 16'($urandom) : to_bcd($urandom_range(0, 1500));
            reset      = ($urandom_range(0, 499) == 0);
            step("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
